// File: rtl/bcd_to_binary_seq_if.sv
// Handshake bundle for the BCD-to-binary converter: BCD input side and
// binary result side, each with its own valid/ready pair.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           binary;
  logic                  out_error;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, binary, out_error
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, binary, out_error
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble,
// one shift/correct iteration per clock.
//
// state   | meaning
// IDLE    | waiting for an input, in_ready high
// CONVERT | BIN_W shift/correct iterations in progress, busy high
// DONE    | result held on out_valid until out_ready
module bcd_to_binary_seq #(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic                clock,
  input  logic                resetn,
  bcd_to_binary_seq_if.slave  bus,
  output logic                busy
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [SR_W-1:0]   sr, sr_nxt, sr_step;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              err, err_nxt;
  logic              digit_err;
  logic              out_valid_q, out_valid_nxt;
  logic [31:0]       binary_q, binary_nxt;
  logic              out_error_q, out_error_nxt;

  // One iteration: shift right, then pull every BCD digit >= 8 down by 3.
  // Corrections stay inside each 4-bit field; no borrow between digits.
  always_comb begin
    sr_step = sr >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_step[BIN_W+4*d +: 4] >= 4'd8)
        sr_step[BIN_W+4*d +: 4] = sr_step[BIN_W+4*d +: 4] - 4'd3;
    end
  end

  always_comb begin
    digit_err = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.bcd_in[4*d +: 4] > 4'd9)
        digit_err = 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    sr_nxt        = sr;
    cnt_nxt       = cnt;
    err_nxt       = err;
    out_valid_nxt = out_valid_q;
    binary_nxt    = binary_q;
    out_error_nxt = out_error_q;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          sr_nxt    = {bus.bcd_in, {BIN_W{1'b0}}};
          err_nxt   = digit_err;
          cnt_nxt   = '0;
          state_nxt = S_CONVERT;
        end
      end
      S_CONVERT: begin
        sr_nxt  = sr_step;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(BIN_W-1)) begin
          state_nxt     = S_DONE;
          out_valid_nxt = 1'b1;
          binary_nxt    = err ? 32'd0 : 32'(sr_step[BIN_W-1:0]);
          out_error_nxt = err;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      sr          <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      out_valid_q <= 1'b0;
      binary_q    <= '0;
      out_error_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      sr          <= sr_nxt;
      cnt         <= cnt_nxt;
      err         <= err_nxt;
      out_valid_q <= out_valid_nxt;
      binary_q    <= binary_nxt;
      out_error_q <= out_error_nxt;
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.binary    = binary_q;
  assign bus.out_error = out_error_q;
  assign busy          = (state == S_CONVERT);

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the score BCD path.
- Accepts DIGITS packed BCD digits, e.g. a high-score or setting value entered digit-wise on the board.
- Returns the binary value using reverse double dabble: one shift/correct iteration per clock.
- Valid/ready handshakes on both input and output sides.

Parameters:
- DIGITS, 6, number of BCD digits on the input (digit 0 = units in bits [3:0]).
- BIN_W, 20, internal binary width and iteration count; must satisfy 10^DIGITS-1 < 2^BIN_W.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  bcd_in is presented.
- in_ready  output  1  block can accept an input (high only in IDLE).
- bcd_in  input  4*DIGITS  packed BCD digits, units in LSBs.
- out_valid  output  1  binary/out_error hold a result.
- out_ready  input  1  consumer takes the result.
- binary  output  32  result, zero-extended from BIN_W bits.
- out_error  output  1  some input digit was > 9.
- busy  output  1  high in CONVERT.

Behaviour:
- Reset (async assert, sync release) → state IDLE.
  - in_ready=1.
  - out_valid=0, binary=0, out_error=0, busy=0.
  - Shift register and iteration counter cleared.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - in_ready=1.
  - Accept on edge with in_valid=1: load shift register {bcd_in, BIN_W'b0} (4*DIGITS+BIN_W bits).
  - Latch err = OR over digits of (digit > 9).
  - Counter=0; go to CONVERT.
- CONVERT, each edge:
  - Shift the whole register right by 1 (LSB of the BCD field enters the MSB of the binary field).
  - Then, in the same cycle, for every 4-bit BCD field: if value >= 8, subtract 3.
  - Increment the counter.
  - On the edge where the counter==BIN_W-1, the final iteration completes and the state moves to DONE.
- Latency:
  - out_valid rises exactly BIN_W edges after the accept edge (20 at default).
  - in_ready=0 and busy=1 during CONVERT.
- Entering DONE:
  - binary = err ? 0 : zero-extended binary field.
  - out_error = err.
  - out_valid=1.
- DONE:
  - out_valid held; binary and out_error stable until out_ready=1 at an edge.
  - Then out_valid=0 → IDLE.
  - in_ready stays 0 in DONE, so there is no same-edge accept.
  - Back-to-back throughput is one conversion per BIN_W+2 cycles.
- binary and out_error retain their last values after the output handshake, until the next DONE entry.
- in_valid outside IDLE is ignored; bcd_in is not sampled after the accept edge.
- out_ready outside DONE is ignored.
- Error handling: invalid digits still run the full conversion timing; only the reported result is forced to 0.
- Reset mid-CONVERT or in DONE: immediate return to reset values; the partial result is discarded.
- Arithmetic: per-digit correction is 4-bit, never borrows across digits. The BCD field is all zero after BIN_W iterations for valid inputs.

Test Plan:
- bcd_in=24'h000000, out_ready=1 → out_valid exactly 20 edges after accept, binary=0, out_error=0; in_ready returns 1 on the next edge.
- bcd_in=24'h999999 → binary=32'h000F423F (999999), out_error=0; busy high for exactly 20 cycles.
- bcd_in=24'h001234, out_ready=0 for 5 cycles after out_valid → binary=32'h4D2 stable, out_valid held; in_valid pulses during CONVERT/DONE are not accepted.
- bcd_in=24'h00A123 → out_error=1, binary=0, same 20-cycle latency. Next input 24'h000042 → binary=42, out_error=0.
- resetn low at iteration 10 of 24'h555555 → all outputs at reset values immediately. After release, 24'h000007 → binary=7.
- Round-trip, out_ready=1: feed the existing bcd module's digit outputs for 1000 random values 0..999999 → binary equals the original value; accepts spaced exactly 22 cycles.
